// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : LC-3b IF front end - PC register, imem read handshake, next-PC mux
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_run,
  input  logic [1:0]  pcmux_sel,
  input  logic [15:0] br_target,
  input  logic [15:0] jmp_target,
  input  logic [15:0] trap_vector,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  output logic [15:0] inst_out,
  output logic        inst_valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic [15:0] r_stall;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_sel_pc;
  logic [15:0] w_next_pc;
  logic        w_in_fetch;
  logic        w_in_hold;

  assign w_pc_plus2 = r_pc + 16'd2;

  always_comb begin
    w_sel_pc = w_pc_plus2;
    case (pcmux_sel)
      2'b00:   w_sel_pc = w_pc_plus2;
      2'b01:   w_sel_pc = br_target;
      2'b10:   w_sel_pc = jmp_target;
      2'b11:   w_sel_pc = trap_vector;
      default: w_sel_pc = w_pc_plus2;
    endcase
    // Instructions are word aligned; an odd target is silently rounded down.
    w_next_pc = {w_sel_pc[15:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_fetch   = 1'b0;
    w_in_hold    = 1'b0;
    case (r_state)
      FETCH: begin
        w_in_fetch = 1'b1;
        if (imem_resp) w_state_next = HOLD;
      end
      HOLD: begin
        w_in_hold = 1'b1;
        if (pc_run) w_state_next = FETCH;
      end
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_inst  <= 16'h0000;
      r_stall <= 16'h0000;
    end else begin
      if (w_in_fetch && imem_resp) r_inst <= imem_rdata;
      if (w_in_hold) begin
        if (pc_run) r_pc <= w_next_pc;
        else        r_stall <= r_stall + 16'd1;
      end
    end
  end

  // Request/valid are masked during reset so memory sees no request in that cycle.
  assign imem_read    = w_in_fetch && !reset;
  assign inst_valid   = w_in_hold && !reset;
  assign inst_out     = inst_valid ? r_inst : 16'h0000;
  assign imem_address = r_pc;
  assign pc_out       = r_pc;
  assign pc_plus2     = w_pc_plus2;
  assign stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit with a variable-latency memory model
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_run;
  logic [1:0]  pcmux_sel;
  logic [15:0] br_target;
  logic [15:0] jmp_target;
  logic [15:0] trap_vector;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   lat        = 1;
  bit   force_resp = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_run       (pc_run),
    .pcmux_sel    (pcmux_sel),
    .br_target    (br_target),
    .jmp_target   (jmp_target),
    .trap_vector  (trap_vector),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid),
    .pc_out       (pc_out),
    .pc_plus2     (pc_plus2),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Memory model: responds in the lat-th cycle that imem_read is held.
  initial begin
    int cnt;
    cnt        = 0;
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      imem_resp = 1'b0;
      if (force_resp) begin
        imem_resp  = 1'b1;
        imem_rdata = 16'hDEAD;
        force_resp = 0;
        cnt        = 0;
      end else if (imem_read) begin
        cnt++;
        if (cnt >= lat) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(imem_address);
          cnt        = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every new instruction presented is matched against the scoreboard.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (inst_valid && !prev) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_inst: got pc %h inst %h expected none", pc_out, inst_out);
        end else begin
          e = exp_q.pop_front();
          check("inst_out", inst_out, e.inst);
          check("pc_out", pc_out, e.pc);
          check("pc_plus2", pc_plus2, e.pc + 16'd2);
        end
      end
      prev = inst_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic wait_hold();
    int n;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      compared++;
      mismatched++;
      $display("FAIL hold_timeout: got inst_valid 0 expected 1");
    end
  endtask

  task automatic step_hold(input logic run, input logic [1:0] sel);
    pc_run    = run;
    pcmux_sel = sel;
    @(posedge clk);
    #1;
    pc_run    = 1'b0;
    pcmux_sel = 2'b00;
    @(negedge clk);
  endtask

  task automatic goto(input string name, input logic [1:0] sel, input logic [15:0] exp_addr);
    step_hold(1'b1, sel);
    check(name, imem_address, exp_addr);
    push_exp(exp_addr);
    wait_hold();
  endtask

  initial begin
    reset       = 1'b1;
    pc_run      = 1'b0;
    pcmux_sel   = 2'b00;
    br_target   = 16'h3051;
    jmp_target  = 16'h3000;
    trap_vector = 16'h0200;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_read", {15'd0, imem_read}, 16'd0);
    check("rst_inst_valid", {15'd0, inst_valid}, 16'd0);
    check("rst_inst_out", inst_out, 16'h0000);
    check("rst_stall", stall_cycles, 16'h0000);
    check("rst_addr", imem_address, 16'h0000);

    // Single-cycle memory, first fetch from RESET_PC.
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(16'h0000);
    @(negedge clk);
    check("first_read", {15'd0, imem_read}, 16'd1);
    check("first_addr", imem_address, 16'h0000);
    wait_hold();
    check("first_inst", inst_out, 16'h1234);

    // Three-cycle memory; FETCH ignores pc_run/sel.
    lat = 3;
    step_hold(1'b1, 2'b00);
    push_exp(16'h0002);
    for (int i = 0; i < 3; i++) begin
      check("slow_read", {15'd0, imem_read}, 16'd1);
      check("slow_addr", imem_address, 16'h0002);
      check("slow_valid", {15'd0, inst_valid}, 16'd0);
      check("slow_inst", inst_out, 16'h0000);
      pc_run      = 1'b1;
      pcmux_sel   = 2'b11;
      trap_vector = 16'hBEEE;
      @(negedge clk);
    end
    pc_run    = 1'b0;
    pcmux_sel = 2'b00;
    check("slow_pc_kept", pc_out, 16'h0002);

    // Five stall cycles.
    for (int i = 0; i < 5; i++) begin
      check("stall_inst", inst_out, 16'h5A58);
      check("stall_pc", pc_out, 16'h0002);
      check("stall_no_read", {15'd0, imem_read}, 16'd0);
      @(negedge clk);
    end
    check("stall_count", stall_cycles, 16'd5);
    lat = 1;
    goto("resume_addr", 2'b00, 16'h0004);

    // Redirects.
    trap_vector = 16'h0200;
    goto("jmp_3000", 2'b10, 16'h3000);
    jmp_target = 16'h4000;
    goto("br_3050", 2'b01, 16'h3050);
    br_target = 16'h3001;
    goto("br_back", 2'b01, 16'h3000);
    goto("jmp_4000", 2'b10, 16'h4000);
    goto("br_back2", 2'b01, 16'h3000);
    goto("trap_0200", 2'b11, 16'h0200);

    // PC wrap and odd-target rounding.
    trap_vector = 16'hFFFF;
    goto("trap_odd", 2'b11, 16'hFFFE);
    check("wrap_plus2", pc_plus2, 16'h0000);
    goto("wrap_fetch", 2'b00, 16'h0000);

    // Stall counter wrap.
    check("stall_before_wrap", stall_cycles, 16'd5);
    repeat (65530) @(negedge clk);
    check("stall_ffff", stall_cycles, 16'hFFFF);
    @(negedge clk);
    check("stall_wrap", stall_cycles, 16'h0000);

    // Reset during a pending slow fetch, resp coincident with reset.
    lat        = 3;
    jmp_target = 16'h5000;
    step_hold(1'b1, 2'b10);
    check("pend_addr", imem_address, 16'h5000);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    force_resp = 1;
    @(negedge clk);
    check("rst_mid_read", {15'd0, imem_read}, 16'd0);
    check("rst_mid_valid", {15'd0, inst_valid}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(16'h0000);
    @(negedge clk);
    check("after_rst_read", {15'd0, imem_read}, 16'd1);
    check("after_rst_addr", imem_address, 16'h0000);
    check("after_rst_valid", {15'd0, inst_valid}, 16'd0);
    check("after_rst_stall", stall_cycles, 16'h0000);
    @(negedge clk);
    check("after_rst_valid2", {15'd0, inst_valid}, 16'd0);
    wait_hold();
    check("after_rst_inst", inst_out, 16'h1234);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the pipelined LC-3b core. Owns the PC register and the instruction-memory read handshake, and presents one fetched instruction per turn to the IF-stage PC/hazard controller. It consumes that controller's `pc_run`/`pcmux_sel` decisions to select the next PC: sequential, branch/JSR offset target, JMP/JSRR base register, or TRAP vector. It also keeps a stall-cycle counter for performance debug.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; all state returns to reset values on the edge where reset=1
- pc_run  in  1  from IF controller; 1 = current instruction may retire from IF
- pcmux_sel  in  2  next-PC select: 00 pc+2, 01 br_target, 10 jmp_target, 11 trap_vector
- br_target  in  16  PC-offset adder result (BR/JSR)
- jmp_target  in  16  base-register value (JMP/RET/JSRR)
- trap_vector  in  16  zero-extended word read from trap vector table
- imem_address  out  16  instruction memory address (always equals pc)
- imem_read  out  1  read request, held until imem_resp
- imem_rdata  in  16  instruction word, valid when imem_resp=1
- imem_resp  in  1  one-cycle read completion strobe
- inst_out  out  16  instruction to IF controller; 16'h0000 (BR never = NOP) when inst_valid=0
- inst_valid  out  1  inst_out holds a fetched instruction
- pc_out  out  16  address of inst_out
- pc_plus2  out  16  pc_out + 2, modulo 2^16
- stall_cycles  out  16  count of cycles with inst_valid=1 and pc_run=0, wraps

## Operation
- Registers: pc (16), inst_reg (16), state {FETCH, HOLD}, stall_cycles (16).
- FETCH: imem_read=1, imem_address=pc, inst_valid=0, inst_out=16'h0000. pc_run and pcmux_sel are ignored; pc holds. When imem_resp=1: inst_reg <= imem_rdata, go to HOLD.
- HOLD: imem_read=0, inst_valid=1, inst_out=inst_reg, pc_out=pc.
  - pc_run=0: stay in HOLD; stall_cycles += 1.
  - pc_run=1: pc <= next_pc, go to FETCH.
- next_pc by pcmux_sel: 00 pc+2; 01 br_target; 10 jmp_target; 11 trap_vector. Bit 0 of the selected value is forced to 0. All additions are 16-bit and wrap (0xFFFE+2 = 0x0000).
- imem_address and imem_read stay stable from request until imem_resp. imem_resp outside FETCH is ignored.
- Memory shares the same reset and abandons in-flight requests on reset.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, inst_reg=0, stall_cycles=0. While reset=1, imem_read=0, inst_valid=0, inst_out=0. imem_read=1 from the first cycle after reset deasserts.
- Reset mid-fetch or mid-hold: the current transaction is discarded and the PC restarts at RESET_PC.
- Latency: an imem_resp in cycle N gives inst_valid=1 in cycle N+1. pc_run=1 in HOLD cycle M gives imem_read=1 with the new address in cycle M+1.
- Minimum per-instruction period = memory latency + 1 HOLD cycle. With 1-cycle memory: FETCH, HOLD, FETCH, ...
- A redirect selected in HOLD replaces the sequential fetch. No wrong-path fetch is issued.
- imem_resp=1 and reset=1 in the same cycle: reset wins and the data is dropped.

## Test plan
- Reset, then 1-cycle memory returning 16'h1234 at 0x0000: imem_read rises on the first cycle after reset; inst_valid=1 with inst_out=16'h1234 and pc_out=0x0000 one cycle after resp; with pc_run=1 and sel=00 the next imem_address is 0x0002.
- 3-cycle memory latency: imem_read and imem_address stay constant for 3 cycles; inst_out=0 and inst_valid=0 throughout; the sel/pc_run inputs applied in FETCH have no effect on pc.
- Hold pc_run=0 for 5 HOLD cycles: inst_out and pc_out stay stable, stall_cycles=5, and no imem_read is issued; pc_run=1 then resumes.
- Redirects from pc=0x3000 in HOLD:
  - sel=01, br_target=0x3051: next fetch at 0x3050.
  - sel=10, jmp_target=0x4000: next fetch at 0x4000.
  - sel=11, trap_vector=0x0200: next fetch at 0x0200.
- Wrap: pc=0xFFFE, sel=00: pc_plus2=0x0000 and next fetch at 0x0000. Separately, stall_cycles at 0xFFFF plus one stall cycle reads 0x0000.
- Assert reset during a pending 3-cycle fetch at 0x5000, with resp arriving in the reset cycle: data is dropped; after reset, the fetch is at RESET_PC with inst_valid=0 until the new resp.
